// File: rtl/apu_mem_arbiter.sv
// apu_mem_arbiter
//
// Shares one 16-bit memory port between two requesters: port 0 (the APU)
// and port 1 (CPU or DMA). Each requester holds its read or write enable
// until it sees a one-cycle acknowledge, exactly as it would with the
// memory attached directly. Only one transaction is outstanding on the
// memory side at a time.
//
// Parameters
//   APU_PRIORITY  1: port 0 wins every contention; 0: round-robin
//   TIMEOUT       BUSY cycles before a transaction is aborted (0 = never)
//
// Ports
//   clk, rst                     clock, asynchronous active-low reset
//   reqAddress0/1, reqDataOut0/1 requester address and write data
//   reqWriteEnable0/1            write request, held until acknowledge
//   reqReadEnable0/1             read request, held until acknowledge
//   reqReadRAM0/1                memory select forwarded to memReadRAM
//   reqDataIn0/1                 read data, non-zero only with an acknowledge
//   reqDataReady0/1              one-cycle read acknowledge
//   reqWriteAcknowledge0/1       one-cycle write acknowledge
//   memAddress, memDataOut, memWriteEnable, memReadEnable, memReadRAM
//                                registered memory-side request
//   memDataIn, memDataReady, memWriteAcknowledge
//                                memory response
//   owner                        port holding the grant (BUSY/DONE)
//   timeoutFlag                  sticky, set by any watchdog abort
module apu_mem_arbiter #(
  parameter int APU_PRIORITY = 0,
  parameter int TIMEOUT      = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] reqAddress0,
  input  logic [15:0] reqDataOut0,
  input  logic        reqWriteEnable0,
  input  logic        reqReadEnable0,
  input  logic        reqReadRAM0,
  output logic [15:0] reqDataIn0,
  output logic        reqDataReady0,
  output logic        reqWriteAcknowledge0,
  input  logic [31:0] reqAddress1,
  input  logic [15:0] reqDataOut1,
  input  logic        reqWriteEnable1,
  input  logic        reqReadEnable1,
  input  logic        reqReadRAM1,
  output logic [15:0] reqDataIn1,
  output logic        reqDataReady1,
  output logic        reqWriteAcknowledge1,
  output logic [31:0] memAddress,
  output logic [15:0] memDataOut,
  output logic        memWriteEnable,
  output logic        memReadEnable,
  output logic        memReadRAM,
  input  logic [15:0] memDataIn,
  input  logic        memDataReady,
  input  logic        memWriteAcknowledge,
  output logic        owner,
  output logic        timeoutFlag
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // With TIMEOUT = 0 this wraps to all ones, but the watchdog is gated off.
  localparam logic [15:0] WATCHDOG_LAST = 16'(TIMEOUT - 1);

  state_t      state;
  logic        rr_pointer;
  logic [15:0] watchdog;

  logic        want_0;
  logic        want_1;
  logic        grant_port;
  logic [31:0] sel_address;
  logic [15:0] sel_data;
  logic        sel_write;
  logic        sel_read;
  logic        sel_ram;
  logic        mem_ack;
  logic        watchdog_expired;
  logic [15:0] finish_data;

  assign want_0 = reqWriteEnable0 | reqReadEnable0;
  assign want_1 = reqWriteEnable1 | reqReadEnable1;

  // Contention is resolved by the fixed APU preference or by the
  // round-robin pointer, which always points away from the last owner.
  always_comb begin
    grant_port = 1'b0;
    if (want_0 && want_1) begin
      grant_port = (APU_PRIORITY != 0) ? 1'b0 : rr_pointer;
    end else if (want_1) begin
      grant_port = 1'b1;
    end
  end

  assign sel_address = grant_port ? reqAddress1     : reqAddress0;
  assign sel_data    = grant_port ? reqDataOut1     : reqDataOut0;
  assign sel_write   = grant_port ? reqWriteEnable1 : reqWriteEnable0;
  assign sel_read    = grant_port ? reqReadEnable1  : reqReadEnable0;
  assign sel_ram     = grant_port ? reqReadRAM1     : reqReadRAM0;

  // While BUSY the registered write enable tells which acknowledge type
  // completes the transaction; the other type is ignored.
  assign mem_ack          = memWriteEnable ? memWriteAcknowledge : memDataReady;
  assign watchdog_expired = (TIMEOUT != 0) && (watchdog == WATCHDOG_LAST);
  assign finish_data      = mem_ack ? memDataIn : 16'h0000;

  // Single FSM: all memory-side and requester-side outputs are registered
  // here. Requester acknowledges are written on the BUSY->DONE edge so
  // they are visible for exactly the DONE cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state                <= IDLE;
      rr_pointer           <= 1'b0;
      owner                <= 1'b0;
      watchdog             <= 16'h0000;
      timeoutFlag          <= 1'b0;
      memAddress           <= 32'h0000_0000;
      memDataOut           <= 16'h0000;
      memWriteEnable       <= 1'b0;
      memReadEnable        <= 1'b0;
      memReadRAM           <= 1'b0;
      reqDataIn0           <= 16'h0000;
      reqDataReady0        <= 1'b0;
      reqWriteAcknowledge0 <= 1'b0;
      reqDataIn1           <= 16'h0000;
      reqDataReady1        <= 1'b0;
      reqWriteAcknowledge1 <= 1'b0;
    end else begin
      reqDataIn0           <= 16'h0000;
      reqDataReady0        <= 1'b0;
      reqWriteAcknowledge0 <= 1'b0;
      reqDataIn1           <= 16'h0000;
      reqDataReady1        <= 1'b0;
      reqWriteAcknowledge1 <= 1'b0;

      case (state)
        IDLE: begin
          if (want_0 || want_1) begin
            owner          <= grant_port;
            memAddress     <= sel_address;
            memDataOut     <= sel_data;
            memReadRAM     <= sel_ram;
            // A port raising both enables is served as a write.
            memWriteEnable <= sel_write;
            memReadEnable  <= sel_read & ~sel_write;
            watchdog       <= 16'h0000;
            state          <= BUSY;
          end
        end

        BUSY: begin
          if (mem_ack || watchdog_expired) begin
            if (!mem_ack) begin
              timeoutFlag <= 1'b1;
            end
            memWriteEnable <= 1'b0;
            memReadEnable  <= 1'b0;
            if (owner) begin
              reqDataIn1           <= finish_data;
              reqDataReady1        <= ~memWriteEnable;
              reqWriteAcknowledge1 <= memWriteEnable;
            end else begin
              reqDataIn0           <= finish_data;
              reqDataReady0        <= ~memWriteEnable;
              reqWriteAcknowledge0 <= memWriteEnable;
            end
            state <= DONE;
          end else begin
            watchdog <= watchdog + 16'd1;
          end
        end

        DONE: begin
          // Requests are not sampled here, which gives the finishing
          // requester a cycle to drop its enable.
          rr_pointer <= ~owner;
          state      <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apu_mem_arbiter.sv
// tb_apu_mem_arbiter
//
// Two arbiter instances run side by side: env[0] is round-robin with a
// six-cycle watchdog, env[1] is APU-first with the watchdog disabled.
// Each environment has a random requester pair, a memory model whose
// latency is a function of the address, a mid-transaction reset, and a
// monitor holding a transaction-level reference model fed by per-port
// queues of issued requests.
module tb_apu_mem_arbiter;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [15:0] data;
    bit          ram;
  } txn_t;

  localparam int NUM_TXN = 40;

  logic clk = 1'b0;
  int   tests_run = 0;
  int   tests_failed = 0;
  int   done_count = 0;

  always #5 clk = ~clk;

  // Memory acknowledges in BUSY cycle lat_of(addr) + 1.
  function automatic int lat_of(input logic [31:0] a);
    return int'(a[2:0]);
  endfunction

  function automatic logic [15:0] mem_word(input logic [31:0] a);
    return a[15:0] ^ a[31:16] ^ 16'hC3A5;
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : env
    localparam int PRI = g;
    localparam int TO  = (g == 0) ? 6 : 0;
    localparam int E   = g;

    logic        rst;
    logic [31:0] addr  [2];
    logic [15:0] wdata [2];
    logic        we    [2];
    logic        re    [2];
    logic        ram   [2];
    logic [15:0] rdata [2];
    logic        drdy  [2];
    logic        wack  [2];
    logic [31:0] mem_address;
    logic [15:0] mem_data_out;
    logic        mem_we;
    logic        mem_re;
    logic        mem_ram;
    logic [15:0] mem_data_in;
    logic        mem_data_ready;
    logic        mem_wack;
    logic        owner;
    logic        timeout_flag;
    txn_t        q0 [$];
    txn_t        q1 [$];

    apu_mem_arbiter #(
      .APU_PRIORITY(PRI),
      .TIMEOUT(TO)
    ) dut (
      .clk(clk),
      .rst(rst),
      .reqAddress0(addr[0]),
      .reqDataOut0(wdata[0]),
      .reqWriteEnable0(we[0]),
      .reqReadEnable0(re[0]),
      .reqReadRAM0(ram[0]),
      .reqDataIn0(rdata[0]),
      .reqDataReady0(drdy[0]),
      .reqWriteAcknowledge0(wack[0]),
      .reqAddress1(addr[1]),
      .reqDataOut1(wdata[1]),
      .reqWriteEnable1(we[1]),
      .reqReadEnable1(re[1]),
      .reqReadRAM1(ram[1]),
      .reqDataIn1(rdata[1]),
      .reqDataReady1(drdy[1]),
      .reqWriteAcknowledge1(wack[1]),
      .memAddress(mem_address),
      .memDataOut(mem_data_out),
      .memWriteEnable(mem_we),
      .memReadEnable(mem_re),
      .memReadRAM(mem_ram),
      .memDataIn(mem_data_in),
      .memDataReady(mem_data_ready),
      .memWriteAcknowledge(mem_wack),
      .owner(owner),
      .timeoutFlag(timeout_flag)
    );

    // Power-on reset, then one reset pulled low while a transaction is BUSY.
    initial begin : reset_ctl
      int i;
      rst = 1'b1;
      #2 rst = 1'b0;
      repeat (3) @(posedge clk);
      #2 rst = 1'b1;
      repeat (90 + 20 * E) @(posedge clk);
      @(negedge clk);
      i = 0;
      while (i < 200 && !(mem_we || mem_re)) begin
        @(negedge clk);
        i++;
      end
      check_output($sformatf("e%0d busy before reset", E), 32'(mem_we | mem_re), 32'd1);
      #1 rst = 1'b0;
      #1;
      check_output($sformatf("e%0d async reset memWriteEnable", E), 32'(mem_we), 32'd0);
      check_output($sformatf("e%0d async reset memReadEnable", E), 32'(mem_re), 32'd0);
      check_output($sformatf("e%0d async reset memAddress", E), mem_address, 32'd0);
      check_output($sformatf("e%0d async reset acks", E),
                   32'({drdy[0], wack[0], drdy[1], wack[1]}), 32'd0);
      repeat (2) @(posedge clk);
      #2 rst = 1'b1;
    end

    // Memory model: answers with the correct acknowledge type in BUSY cycle
    // lat_of(addr)+1, sprinkles the wrong type and junk data before that.
    initial begin : memory_model
      int cnt;
      bit hit;
      bit wrong;
      cnt = 0;
      mem_data_in    = 16'h0000;
      mem_data_ready = 1'b0;
      mem_wack       = 1'b0;
      forever begin
        @(posedge clk);
        #1;
        if (mem_we || mem_re) cnt++;
        else cnt = 0;
        hit   = (cnt != 0) && (cnt == lat_of(mem_address) + 1);
        wrong = ($urandom_range(0, 2) == 0);
        if (mem_we) begin
          mem_wack       = hit;
          mem_data_ready = wrong;
        end else if (mem_re) begin
          mem_data_ready = hit;
          mem_wack       = wrong;
        end else begin
          mem_data_ready = 1'b0;
          mem_wack       = 1'b0;
        end
        mem_data_in = hit ? mem_word(mem_address) : 16'($urandom);
      end
    end

    function automatic int new_gap(input int p);
      if (E == 0) return $urandom_range(0, 3);
      if (p == 0) return ($urandom_range(0, 3) == 0) ? $urandom_range(2, 6) : 0;
      return $urandom_range(0, 1);
    endfunction

    // Requester pair: each port issues NUM_TXN transactions, holds them until
    // acknowledged, drops the enable for at least one cycle, and sometimes
    // both ports start in the same cycle to force contention.
    initial begin : applyStimulus
      int   remaining [2];
      int   gap       [2];
      bit   active    [2];
      bit   acked     [2];
      bit   dropped   [2];
      int   cycles;
      txn_t t;
      for (int p = 0; p < 2; p++) begin
        we[p] = 1'b0; re[p] = 1'b0; ram[p] = 1'b0;
        addr[p] = 32'd0; wdata[p] = 16'd0;
        remaining[p] = NUM_TXN; gap[p] = 0; active[p] = 1'b0;
        acked[p] = 1'b0; dropped[p] = 1'b0;
      end
      repeat (5) @(posedge clk);
      cycles = 0;
      while ((remaining[0] > 0 || remaining[1] > 0) && cycles < 8000) begin
        @(negedge clk);
        for (int p = 0; p < 2; p++) acked[p] = drdy[p] | wack[p];
        @(posedge clk);
        #1;
        cycles++;
        for (int p = 0; p < 2; p++) begin
          dropped[p] = 1'b0;
          if (active[p] && acked[p]) begin
            we[p] = 1'b0; re[p] = 1'b0; addr[p] = $urandom;
            active[p] = 1'b0; remaining[p]--; dropped[p] = 1'b1;
            gap[p] = new_gap(p);
          end
        end
        if (!active[0] && !active[1] && !dropped[0] && !dropped[1] &&
            $urandom_range(0, 1) == 1) begin
          gap[0] = 0;
          gap[1] = 0;
        end
        for (int p = 0; p < 2; p++) begin
          if (!active[p] && !dropped[p] && remaining[p] > 0) begin
            if (gap[p] == 0) begin
              t.wr   = ($urandom_range(0, 1) == 1);
              t.addr = $urandom;
              t.data = 16'($urandom);
              t.ram  = ($urandom_range(0, 1) == 1);
              addr[p]  = t.addr;
              wdata[p] = t.data;
              ram[p]   = t.ram;
              we[p]    = t.wr;
              re[p]    = !t.wr || ($urandom_range(0, 3) == 0);
              if (p == 0) q0.push_back(t);
              else q1.push_back(t);
              active[p] = 1'b1;
            end else begin
              gap[p]--;
            end
          end
        end
      end
      check_output($sformatf("e%0d transactions left", E), 32'(remaining[0] + remaining[1]), 32'd0);
      check_output($sformatf("e%0d port0 queue empty", E), 32'(q0.size()), 32'd0);
      check_output($sformatf("e%0d port1 queue empty", E), 32'(q1.size()), 32'd0);
      done_count++;
    end

    // Monitor with reference model: decides grants from the queued requests
    // and compares the DUT every cycle on the falling edge.
    initial begin : checkOutput
      bit          in_busy;
      bit          in_done;
      bit          next_busy;
      bit          next_done;
      bit          exp_timeout;
      bit          flag_model;
      bit          r0;
      bit          r1;
      int          rr;
      int          busy_cnt;
      int          own;
      txn_t        cur;
      logic [15:0] exp_read;
      in_busy = 1'b0; in_done = 1'b0; exp_timeout = 1'b0; flag_model = 1'b0;
      rr = 0; busy_cnt = 0; own = 0;
      forever begin
        @(negedge clk);
        if (!rst) begin
          in_busy = 1'b0; in_done = 1'b0; rr = 0; busy_cnt = 0; flag_model = 1'b0;
          check_output($sformatf("e%0d reset mem enables", E), 32'({mem_we, mem_re}), 32'd0);
          check_output($sformatf("e%0d reset memAddress", E), mem_address, 32'd0);
          check_output($sformatf("e%0d reset memDataOut/RAM", E), 32'({mem_data_out, mem_ram}), 32'd0);
          check_output($sformatf("e%0d reset owner/flag", E), 32'({owner, timeout_flag}), 32'd0);
          check_output($sformatf("e%0d reset req acks", E),
                       32'({drdy[0], wack[0], drdy[1], wack[1]}), 32'd0);
          check_output($sformatf("e%0d reset req data", E), {rdata[1], rdata[0]}, 32'd0);
          continue;
        end

        next_busy = 1'b0;
        next_done = 1'b0;

        if (in_busy) begin
          check_output($sformatf("e%0d memWriteEnable", E), 32'(mem_we), 32'(cur.wr));
          check_output($sformatf("e%0d memReadEnable", E), 32'(mem_re), 32'(!cur.wr));
          check_output($sformatf("e%0d memAddress", E), mem_address, cur.addr);
          check_output($sformatf("e%0d memDataOut", E), 32'(mem_data_out), 32'(cur.data));
          check_output($sformatf("e%0d memReadRAM", E), 32'(mem_ram), 32'(cur.ram));
          check_output($sformatf("e%0d owner busy", E), 32'(owner), 32'(own));
          if (busy_cnt == lat_of(cur.addr) + 1) begin
            next_done = 1'b1;
            exp_timeout = 1'b0;
          end else if (TO != 0 && busy_cnt == TO) begin
            next_done = 1'b1;
            exp_timeout = 1'b1;
          end else begin
            next_busy = 1'b1;
          end
          busy_cnt++;
        end else begin
          check_output($sformatf("e%0d mem enables idle", E), 32'({mem_we, mem_re}), 32'd0);
        end

        if (in_done) begin
          if (exp_timeout) flag_model = 1'b1;
          exp_read = exp_timeout ? 16'h0000 : mem_word(cur.addr);
          check_output($sformatf("e%0d owner done", E), 32'(owner), 32'(own));
          check_output($sformatf("e%0d p%0d dataReady", E, own), 32'(drdy[own]), 32'(!cur.wr));
          check_output($sformatf("e%0d p%0d writeAck", E, own), 32'(wack[own]), 32'(cur.wr));
          if (!cur.wr)
            check_output($sformatf("e%0d p%0d read data", E, own), 32'(rdata[own]), 32'(exp_read));
          check_output($sformatf("e%0d p%0d idle outputs", E, 1 - own),
                       32'({rdata[1 - own], drdy[1 - own], wack[1 - own]}), 32'd0);
          if (own == 0) void'(q0.pop_front());
          else void'(q1.pop_front());
          rr = 1 - own;
        end else begin
          check_output($sformatf("e%0d no acks", E),
                       32'({drdy[0], wack[0], drdy[1], wack[1]}), 32'd0);
          check_output($sformatf("e%0d no req data", E), {rdata[1], rdata[0]}, 32'd0);
        end

        check_output($sformatf("e%0d timeoutFlag", E), 32'(timeout_flag), 32'(flag_model));

        if (!in_busy && !in_done) begin
          r0 = we[0] | re[0];
          r1 = we[1] | re[1];
          if (r0 || r1) begin
            if (r0 && r1) own = (PRI != 0) ? 0 : rr;
            else own = r0 ? 0 : 1;
            tests_run++;
            if ((own == 0 && q0.size() == 0) || (own == 1 && q1.size() == 0)) begin
              tests_failed++;
              $display("[TB] FAIL e%0d grant: port %0d requesting with no queued transaction", E, own);
            end else begin
              cur = (own == 0) ? q0[0] : q1[0];
              next_busy = 1'b1;
              busy_cnt = 1;
            end
          end
        end

        in_busy = next_busy;
        in_done = next_done;
      end
    end
  end

  initial begin : summary
    int waited;
    waited = 0;
    while (done_count < 2 && waited < 20000) begin
      @(posedge clk);
      waited++;
    end
    check_output("all environments finished", 32'(done_count), 32'd2);
    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/apu_mem_arbiter.md
# apu_mem_arbiter

Two-port memory arbiter that shares one 16-bit memory port (main RAM / program BRAM) between the APU and a second requester (CPU or DMA). Each requester sees the same read/write handshake it would see connected directly to memory: enable held until a one-cycle acknowledge. The arbiter serialises transactions, grants in round-robin or APU-first order, and aborts transactions that the memory never acknowledges.

## Interface
- APU_PRIORITY, default 0: 1 = port 0 (APU) always wins contention; 0 = round-robin.
- TIMEOUT, default 255: BUSY cycles before abort, range 1..65535; 0 disables the watchdog.
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  reset, asynchronous, active-low (0 = reset).
- reqAddress0 / reqAddress1  in  32  requester address.
- reqDataOut0 / reqDataOut1  in  16  requester write data.
- reqWriteEnable0 / 1  in  1  write request, level, held until acknowledge.
- reqReadEnable0 / 1  in  1  read request, level, held until acknowledge.
- reqReadRAM0 / 1  in  1  memory select (1 = main RAM, 0 = BRAM), forwarded.
- reqDataIn0 / reqDataIn1  out  16  read data, valid only with reqDataReady.
- reqDataReady0 / 1  out  1  one-cycle read acknowledge.
- reqWriteAcknowledge0 / 1  out  1  one-cycle write acknowledge.
- memAddress  out  32;  memDataOut  out  16;  memWriteEnable  out  1;  memReadEnable  out  1;  memReadRAM  out  1: registered memory-side request.
- memDataIn  in  16;  memDataReady  in  1;  memWriteAcknowledge  in  1: memory response.
- owner  out  1  port holding the grant (valid in BUSY/DONE).
- timeoutFlag  out  1  sticky, set on any watchdog abort.

## Operation
- States: IDLE, BUSY, DONE.
- IDLE: a port requests if read or write enable is high. No request: stay. One requester: grant it. Both: APU_PRIORITY=1 → port 0; else port given by rrPointer. On grant: latch owner; register owner's address, data, readRAM and enables onto mem*; clear watchdog counter; go BUSY.
- Read and write both high on one port: treated as write; memReadEnable stays 0.
- BUSY: mem* held constant. memWriteAcknowledge (write) or memDataReady (read) high → capture memDataIn, drop mem enables, go DONE. Acknowledge of the wrong type is ignored.
- Watchdog: counter increments each BUSY cycle without acknowledge; when TIMEOUT≠0 and counter reaches TIMEOUT-1 → drop enables, set timeoutFlag, capture data 16'h0000, go DONE.
- DONE: pulse the owner's reqDataReady (read) or reqWriteAcknowledge (write) with reqDataIn = captured data; the other port's outputs stay 0. rrPointer ← ~owner. Go IDLE. Requests are not sampled in DONE, so the finishing requester can drop its enable without a duplicate grant.
- Requests from the non-owner are held pending, never dropped or acknowledged.
- reqDataIn of the non-acknowledged port is 16'h0000.

## Timing
- Reset (rst=0, asynchronous): state IDLE, rrPointer 0, owner 0, counter 0, timeoutFlag 0, every mem* output 0, every req* output 0.
- Request high in IDLE at cycle N → mem enables high at N+1.
- Memory acknowledge at cycle M (≥N+1) → req acknowledge and data at M+1 for exactly one cycle; mem enables 0 at M+1.
- Earliest next grant: sampled at M+2, enables at M+3. Minimum 3 cycles per transaction with a zero-wait memory (acknowledge tied 1).
- Timeout with TIMEOUT=T: enables high for exactly T cycles, acknowledge pulse on the following cycle.
- rst asserted mid-transaction: transaction abandoned, no acknowledge issued; after release, still-requesting ports are re-arbitrated from rrPointer 0.
- Requester contract: address/data/enables stable from assertion until acknowledge; enable dropped the cycle after acknowledge.

## Test plan
- APU read alone, memory acknowledges immediately, memDataIn=16'h1234 at address 5 → memReadEnable high one cycle; reqDataReady0 one cycle later with reqDataIn0=16'h1234; port 1 outputs stay 0.
- Both ports write continuously, APU_PRIORITY=0, ack tied 1 → grants 0,1,0,1 starting with port 0, one transfer every 3 cycles, each write acknowledged exactly once.
- Same stimulus with APU_PRIORITY=1 → port 1 is never granted while port 0 requests; granted when port 0 idles.
- Port 1 write, memWriteAcknowledge delayed 7 cycles, port 0 read arrives meanwhile → mem* stay frozen 7 cycles; port 1 acknowledged; port 0 granted two cycles after port 1's acknowledge.
- TIMEOUT=4, acknowledges tied 0, port 0 read → enables high 4 cycles; reqDataReady0 with 16'h0000; timeoutFlag=1 and stays 1 until reset.
- rst pulled low during BUSY → all outputs 0 immediately with no acknowledge; after release the held request is re-granted, completes normally.
